// File: rtl/sccb_write_master.sv
`default_nettype none
// ============================================================================
// Module   : sccb_write_master
// Purpose  : SCCB (camera control bus) 3-phase write master. One accepted
//            request sends {CAMERA_ID, addr, data} as 27 bit slots
//            (3 bytes, each followed by a released don't-care/ACK slot),
//            framed by a start and a stop condition, on open-drain lines.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk     in   1  system clock, rising edge
//   rst_n   in   1  asynchronous active-low reset
//   clk_en  in   1  clock enable; everything holds while low
//   start   in   1  write request, only looked at in IDLE
//   addr    in   8  register sub-address, latched on accept
//   data    in   8  register write data, latched on accept
//   ready   out  1  high in IDLE only
//   SIOC_oe out  1  1 pulls SIOC low, 0 releases it
//   SIOD_oe out  1  1 pulls SIOD low, 0 releases it
// ============================================================================
module sccb_write_master #(
  parameter int          CLK_FREQ  = 25000000,
  parameter int          SCCB_FREQ = 100000,
  parameter logic [7:0]  CAMERA_ID = 8'h42
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  output logic       ready,
  output logic       SIOC_oe,
  output logic       SIOD_oe
);

  // Enabled cycles per half SIOC period.
  localparam int HALF  = CLK_FREQ / (2 * SCCB_FREQ);
  localparam int CNT_W = (HALF > 2) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(HALF - 1);
  localparam logic [4:0]       LAST_SLOT = 5'd26;

  if (HALF < 2) begin : g_half_check
    $error("sccb_write_master: CLK_FREQ/(2*SCCB_FREQ) must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    BIT_LOW   = 3'd2,
    BIT_HIGH  = 3'd3,
    STOP_LOW  = 3'd4,
    STOP_HIGH = 3'd5,
    GAP       = 3'd6
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [4:0]       bit_cnt, bit_cnt_nx;
  logic [23:0]      shreg, shreg_nx;
  logic             ready_nx, sioc_nx, siod_nx;
  logic             timer_done;

  // Slot 8 of each 9-slot phase is the released ACK slot.
  function automatic logic is_ack_slot(input logic [4:0] slot);
    return (slot == 5'd8) || (slot == 5'd17) || (slot == 5'd26);
  endfunction

  assign timer_done = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      ready   <= 1'b1;
      SIOC_oe <= 1'b0;
      SIOD_oe <= 1'b0;
    end else if (clk_en) begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_cnt <= bit_cnt_nx;
      shreg   <= shreg_nx;
      ready   <= ready_nx;
      SIOC_oe <= sioc_nx;
      SIOD_oe <= siod_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    ready_nx   = ready;
    sioc_nx    = SIOC_oe;
    siod_nx    = SIOD_oe;

    case (state)
      IDLE: begin
        ready_nx = 1'b1;
        sioc_nx  = 1'b0;
        siod_nx  = 1'b0;
        if (start) begin
          shreg_nx   = {CAMERA_ID, addr, data};
          bit_cnt_nx = '0;
          cnt_nx     = HALF_M1;
          ready_nx   = 1'b0;
          siod_nx    = 1'b1;          // start condition: SIOD falls, SIOC high
          state_nx   = START;
        end
      end

      START: begin
        if (timer_done) begin
          state_nx = BIT_LOW;
          cnt_nx   = HALF_M1;
          sioc_nx  = 1'b1;
          // Slot 0 is always a data slot.
          siod_nx  = ~shreg[23];
          shreg_nx = {shreg[22:0], 1'b0};
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end

      BIT_LOW: begin
        if (timer_done) begin
          state_nx = BIT_HIGH;
          cnt_nx   = HALF_M1;
          sioc_nx  = 1'b0;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end

      BIT_HIGH: begin
        if (timer_done) begin
          cnt_nx  = HALF_M1;
          sioc_nx = 1'b1;
          if (bit_cnt == LAST_SLOT) begin
            state_nx = STOP_LOW;
            siod_nx  = 1'b1;
          end else begin
            state_nx   = BIT_LOW;
            bit_cnt_nx = bit_cnt + 5'd1;
            // Data bits are consumed from the MSB; ACK slots leave the
            // shift register untouched so the next byte stays aligned.
            if (is_ack_slot(bit_cnt + 5'd1)) begin
              siod_nx = 1'b0;
            end else begin
              siod_nx  = ~shreg[23];
              shreg_nx = {shreg[22:0], 1'b0};
            end
          end
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end

      STOP_LOW: begin
        if (timer_done) begin
          state_nx = STOP_HIGH;
          cnt_nx   = HALF_M1;
          sioc_nx  = 1'b0;
          siod_nx  = 1'b1;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end

      STOP_HIGH: begin
        if (timer_done) begin
          state_nx = GAP;
          cnt_nx   = HALF_M1;
          siod_nx  = 1'b0;            // stop condition: SIOD rises, SIOC high
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end

      GAP: begin
        if (timer_done) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          ready_nx = 1'b1;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end

      default: begin
        state_nx   = IDLE;
        cnt_nx     = '0;
        bit_cnt_nx = '0;
        ready_nx   = 1'b1;
        sioc_nx    = 1'b0;
        siod_nx    = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire
